// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows for Nb = 4, 6 or 8 columns.
// The permutation is applied before stage 0; later stages only carry data under valid/ready flow control.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inv,
  input  logic [32*NB-1:0] in_block,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] out_block,
  output logic            out_inv,
  output logic            busy
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("shift_rows_pipe: DEPTH must be in 1..4");
  end

  // Nb=8 uses the wider Rijndael offsets {0,1,3,4} on rows 2 and 3.
  function automatic int row_offset(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] blk, input logic inv);
    logic [W-1:0] res;
    int           src;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        if (inv) src = (c - row_offset(r) + NB) % NB;
        else     src = (c + row_offset(r)) % NB;
        res[W-1-32*c-8*r -: 8] = blk[W-1-32*src-8*r -: 8];
      end
    end
    return res;
  endfunction

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] inv_q, inv_d;
  logic [W-1:0]     blk_q [DEPTH];
  logic [W-1:0]     blk_d [DEPTH];
  logic [DEPTH-1:0] load;
  logic [W-1:0]     perm_blk;

  assign perm_blk = shift_rows(in_block, in_inv);

  // A stage may load when it is empty or its contents leave this cycle.
  always_comb begin
    logic down_load;
    down_load = out_ready;
    load      = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      load[k]   = ~vld_q[k] | down_load;
      down_load = load[k];
    end
  end

  assign in_ready = load[0];

  always_comb begin
    vld_d = vld_q;
    inv_d = inv_q;
    for (int k = 0; k < DEPTH; k++) blk_d[k] = blk_q[k];
    if (load[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        blk_d[0] = perm_blk;
        inv_d[0] = in_inv;
      end
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          blk_d[k] = blk_q[k-1];
          inv_d[k] = inv_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      inv_q <= '0;
      for (int k = 0; k < DEPTH; k++) blk_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      inv_q <= inv_d;
      for (int k = 0; k < DEPTH; k++) blk_q[k] <= blk_d[k];
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_block = blk_q[DEPTH-1];
  assign out_inv   = inv_q[DEPTH-1];
  assign busy      = |vld_q;

endmodule
